multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Moore-style main control FSM for the multicycle MIPS-subset datapath. It sequences fetch, decode, execute, memory and writeback for R-type, lw, sw, beq, addi and j. It drives the 3-bit ALUOp into the ALU control block and all datapath mux selects and write enables. It waits on a memory ready handshake, with a timeout, and traps illegal opcodes.

Parameters:
TIMEOUT, 15, maximum cycles to wait for mem_ready in any memory state before trapping; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  6  instruction[31:26] from the IR
mem_ready  input  1  memory has completed the current access this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU zero (beq)
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR
RegDst  output  1  destination register: 0 = rt, 1 = rd
RegWrite  output  1  register file write
ALUSrcA  output  1  ALU A: 0 = PC, 1 = rs
ALUSrcB  output  2  ALU B: 00 = rt, 01 = 4, 10 = signext imm, 11 = signext imm shifted left 2
ALUOp  output  3  000 = funct-decoded, 001 = add, 010 = sub
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
error  output  1  sticky trap flag (illegal opcode or memory timeout)
state_o  output  4  current state encoding, for debug and verification

Behaviour:
Reset and default outputs:
- reset asserted, at any time including mid-instruction: state = IDLE, wait counter = 0, error = 0.
- In IDLE, every output is 0, including ALUOp = 000. state_o = 0.
- IDLE -> FETCH unconditionally on the first clk edge after reset deasserts.

Output rules:
- Outputs are a pure function of state, except the FETCH enables gated by mem_ready.
- Any output not listed for a state is 0.

State encoding, outputs and transitions:
- IDLE (0): all outputs 0 -> FETCH.
- FETCH (1): MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 001, PCSource = 00.
  - IRWrite = PCWrite = mem_ready.
  - Stays in FETCH while mem_ready = 0; -> DECODE on mem_ready = 1.
- DECODE (2): ALUSrcA = 0, ALUSrcB = 11, ALUOp = 001. Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other opcode -> TRAP
- MEMADR (3): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 001 -> MEMRD for lw, MEMWR for sw.
- MEMRD (4): MemRead = 1, IorD = 1. Waits for mem_ready -> MEMWB.
- MEMWB (5): RegWrite = 1, MemtoReg = 1, RegDst = 0 -> FETCH.
- MEMWR (6): MemWrite = 1, IorD = 1. Waits for mem_ready -> FETCH.
- EXEC (7): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 000 -> RTYPEWB.
- RTYPEWB (8): RegWrite = 1, RegDst = 1, MemtoReg = 0 -> FETCH.
- BRANCH (9): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 010, PCWriteCond = 1, PCSource = 01 -> FETCH.
- ADDIEX (10): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 001 -> ADDIWB.
- ADDIWB (11): RegWrite = 1, RegDst = 0, MemtoReg = 0 -> FETCH.
- JUMP (12): PCWrite = 1, PCSource = 10 -> FETCH.
- TRAP (13): all outputs 0, error = 1. Stays in TRAP until reset.

Opcode sampling:
- opcode is sampled in DECODE and in MEMADR only.
- The IR is stable from DECODE onward, so no opcode register is needed inside the block.

Memory wait counter:
- The counter increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready = 0.
- It clears on any state change.
- If the counter reaches TIMEOUT while mem_ready is still 0 -> TRAP on the next edge.
- mem_ready = 1 on the same cycle the counter reaches TIMEOUT: the access completes normally (mem_ready wins).

Cycle counts (mem_ready held high):
- lw: 5 cycles; sw: 4; R-type: 4; addi: 4; beq: 3; j: 3.
- An all-zero instruction (nop) executes as R-type. Its write to $0 is handled by the register file.

Decomposition:
- Shared package/include file holds:
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - ALUOp codes: ALUOP_FUNCT = 000, ALUOP_ADD = 001, ALUOP_SUB = 010
  - state encodings S_IDLE through S_TRAP
  - ALUSrcB and PCSource select codes
- Natural sub-module: mem_wait_timer (counter, clear, timeout compare, parameter TIMEOUT). The FSM and output decode stay in multicycle_control.

Test Plan:
- Reset, then opcode = 000000 with mem_ready = 1 -> state_o sequence 0,1,2,7,8,1. ALUOp = 000 in EXEC; RegWrite = 1 and RegDst = 1 only in RTYPEWB.
- lw (100011) with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles with MemRead = 1, IorD = 1. MEMWB then asserts RegWrite = 1, MemtoReg = 1. error stays 0.
- beq (000100) -> BRANCH asserts PCWriteCond = 1, PCSource = 01, ALUOp = 010, PCWrite = 0. Returns to FETCH after 3 total cycles.
- Illegal opcode 111111 -> DECODE then TRAP. error = 1 and all enables 0 for 20 cycles. Reset returns state_o to 0 and error to 0.
- TIMEOUT = 15, mem_ready held 0 in FETCH -> IRWrite and PCWrite never asserted. TRAP entered 15 cycles after FETCH entry.
- sw in MEMWR with reset asserted mid-wait -> state_o = 0 and MemWrite = 0 immediately (asynchronous). FETCH resumes one cycle after reset release.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS-subset main control FSM.
// Holds opcode values, ALUOp codes, datapath select codes and the state
// encoding. The state encoding is visible on state_o, so it is fixed here.
package multicycle_control_pkg;

  // instruction[31:26] values understood by the control FSM
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp codes sent to the ALU control block
  localparam logic [2:0] ALUOP_FUNCT = 3'b000;
  localparam logic [2:0] ALUOP_ADD   = 3'b001;
  localparam logic [2:0] ALUOP_SUB   = 3'b010;

  // ALU B operand select
  localparam logic [1:0] ALUSRCB_RT    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RTYPEWB = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter for the multicycle control FSM.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : state is changing this cycle; counter returns to 0
//   inc        : FSM is in a memory state and mem_ready is low
//   timeout    : this waiting cycle is the TIMEOUT-th one in a row
// timeout is combinational so the FSM can branch to TRAP on the same edge
// that would otherwise have made the counter reach TIMEOUT.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (inc) begin
      count <= count + 8'd1;
    end
  end

  // count holds the waiting cycles already completed; this cycle is the last
  // allowed one when it equals TIMEOUT-1. A mem_ready in this cycle drops inc,
  // so a completing access always wins over the timeout.
  assign timeout = inc && (count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Moore main control FSM for the multicycle MIPS-subset datapath.
// Sequences fetch/decode/execute/memory/writeback for R-type, lw, sw, beq,
// addi and j, drives every datapath select and write enable, and traps on
// illegal opcodes or a memory access that exceeds TIMEOUT waiting cycles.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   opcode            : IR[31:26], looked at in DECODE and MEMADR only
//   mem_ready         : memory handshake (see below)
//   PCWrite..PCSource : datapath controls
//   error             : high while in TRAP (held until reset)
//   state_o           : current state encoding
// Handshake: MemRead/MemWrite are held as a request for as long as the FSM
// sits in FETCH, MEMRD or MEMWR; the access completes in the cycle where
// mem_ready is 1, and the FSM leaves the state on the following edge.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       error,
  output logic [3:0] state_o
);

  state_t state, state_next;
  logic   waiting;
  logic   timeout;

  assign waiting = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR))
                   && !mem_ready;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_next != state),
    .inc     (waiting),
    .timeout (timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
                else if (timeout) state_next = S_TRAP;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_next = S_EXEC;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_TRAP;
        endcase
      end
      // Only lw/sw reach MEMADR and the IR is stable, so sw vs. not-sw suffices.
      S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
                else if (timeout) state_next = S_TRAP;
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
                else if (timeout) state_next = S_TRAP;
      S_EXEC:   state_next = S_RTYPEWB;
      S_ADDIEX: state_next = S_ADDIWB;
      S_MEMWB, S_RTYPEWB, S_BRANCH, S_ADDIWB, S_JUMP: state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_TRAP;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = ALUSRCB_RT;
    ALUOp       = ALUOP_FUNCT;
    PCSource    = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = ALUSRCB_FOUR;
        ALUOp   = ALUOP_ADD;
        // PC+4 and the IR load only commit once the fetch has completed.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = ALUSRCB_IMMSH;
        ALUOp   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  // TRAP is only left through reset, so error is sticky without extra state.
  assign error   = (state == S_TRAP);
  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. The driver issues one cycle of
// inputs at a time together with the hand-derived state expected in that
// cycle; the expected full output vector is queued and a negedge monitor
// pops and compares it against the DUT.
module tb_multicycle_control;

  localparam int W = 22;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       error;
  } ctl_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, error;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .error       (error),
    .state_o     (state_o)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pops   = 0;

  // Hand-written output table per state (mr only matters in FETCH).
  function automatic ctl_t expect_for(input logic [3:0] st, input logic mr);
    ctl_t c;
    c    = '0;
    c.st = st;
    case (st)
      4'd1:  begin c.mem_read = 1; c.ir_write = mr; c.pc_write = mr;
                   c.alu_src_b = 2'b01; c.alu_op = 3'b001; end
      4'd2:  begin c.alu_src_b = 2'b11; c.alu_op = 3'b001; end
      4'd3:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 3'b001; end
      4'd4:  begin c.mem_read = 1; c.iord = 1; end
      4'd5:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      4'd6:  begin c.mem_write = 1; c.iord = 1; end
      4'd7:  begin c.alu_src_a = 1; c.alu_src_b = 2'b00; c.alu_op = 3'b000; end
      4'd8:  begin c.reg_write = 1; c.reg_dst = 1; end
      4'd9:  begin c.alu_src_a = 1; c.alu_op = 3'b010; c.pc_write_cond = 1;
                   c.pc_source = 2'b01; end
      4'd10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 3'b001; end
      4'd11: begin c.reg_write = 1; end
      4'd12: begin c.pc_write = 1; c.pc_source = 2'b10; end
      4'd13: begin c.error = 1; end
      default: ;
    endcase
    return c;
  endfunction

  // monitor: one expected vector per cycle, compared mid-cycle
  always @(negedge clk) begin
    logic [W-1:0] act, want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      act  = {state_o, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
              MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, error};
      checks++;
      pops++;
      if (act !== want) begin
        errors++;
        $display("FAIL ctl_vector cycle %0d: got state=%0d vec=%h, want state=%0d vec=%h",
                 pops, act[W-1 -: 4], act, want[W-1 -: 4], want);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic [5:0] op, input logic mr, input logic [3:0] st);
    logic [W-1:0] v;
    opcode    = op;
    mem_ready = mr;
    v         = expect_for(st, mr);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step(6'd0, 1'b1, 4'd0);
    reset = 1'b0;
    step(6'd0, 1'b1, 4'd0);
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 6'd0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step(6'd0, 1'b0, 4'd0);          // held in reset
    reset = 1'b0;
    step(6'd0, 1'b1, 4'd0);          // first cycle after release

    // R-type / nop: 1,2,7,8
    step(6'd0, 1, 1); step(6'd0, 1, 2); step(6'd0, 1, 7); step(6'd0, 1, 8);

    // lw with three not-ready cycles in MEMRD
    step(LW, 1, 1); step(LW, 1, 2); step(LW, 1, 3);
    repeat (3) step(LW, 0, 4);
    step(LW, 1, 4); step(LW, 1, 5);

    // beq, sw, addi, j
    step(BEQ, 1, 1); step(BEQ, 1, 2); step(BEQ, 1, 9);
    step(SW, 1, 1); step(SW, 1, 2); step(SW, 1, 3); step(SW, 1, 6);
    step(ADDI, 1, 1); step(ADDI, 1, 2); step(ADDI, 1, 10); step(ADDI, 1, 11);
    step(JMP, 1, 1); step(JMP, 1, 2); step(JMP, 1, 12);

    // mem_ready arrives in the 15th waiting cycle: completes normally
    repeat (14) step(JMP, 0, 1);
    step(JMP, 1, 1); step(JMP, 1, 2); step(JMP, 1, 12);
    // same boundary in MEMWR, also shows the counter restarted from 0
    step(SW, 1, 1); step(SW, 1, 2); step(SW, 1, 3);
    repeat (14) step(SW, 0, 6);
    step(SW, 1, 6);

    // illegal opcode traps and stays trapped regardless of mem_ready
    step(BAD, 1, 1); step(BAD, 1, 2);
    repeat (20) step(BAD, 1'($urandom_range(0, 1)), 13);
    reset_pulse();

    // fetch never ready: 15 cycles in FETCH, then TRAP
    repeat (15) step(6'd0, 0, 1);
    repeat (3) step(6'd0, 0, 13);
    reset_pulse();

    // lw read never ready: 15 cycles in MEMRD, then TRAP
    step(LW, 1, 1); step(LW, 1, 2); step(LW, 1, 3);
    repeat (15) step(LW, 0, 4);
    step(LW, 0, 13);
    reset_pulse();

    // sw with reset asserted mid-wait: outputs drop without a clock edge
    step(SW, 1, 1); step(SW, 1, 2); step(SW, 1, 3);
    step(SW, 0, 6); step(SW, 0, 6);
    reset = 1'b1;
    #1;
    checks++;
    if (state_o !== 4'd0 || MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got state=%0d MemWrite=%0d, want state=0 MemWrite=0",
               state_o, MemWrite);
    end
    step(SW, 0, 0);
    reset = 1'b0;
    step(SW, 1, 0);
    step(SW, 1, 1);                  // FETCH one cycle after release

    // drain the scoreboard with a bounded wait
    begin
      int guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      #1;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d expected vectors left, want 0", exp_q.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
